// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with pixel-RAM addressing, frame-synchronous mode selection and
// sideband delay matched to the pixel source read latency (counter-to-output = RD_LAT+2).
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 4,
    parameter int RD_LAT   = 1
) (
    input  logic                        vga_clk,
    input  logic                        rst,
    input  logic [1:0]                  mode_in,
    input  logic [3*CW-1:0]             fill_color,
    input  logic [3*CW-1:0]             d_in,
    output logic [$clog2(V_ACTIVE)-1:0] row_addr,
    output logic [$clog2(H_ACTIVE)-1:0] col_addr,
    output logic                        rdn,
    output logic [CW-1:0]               r,
    output logic [CW-1:0]               g,
    output logic [CW-1:0]               b,
    output logic                        hs,
    output logic                        vs,
    output logic                        de,
    output logic                        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CAW     = $clog2(H_ACTIVE);
    localparam int RAW     = $clog2(V_ACTIVE);
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACTIVE;
    localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    typedef struct packed {
        logic [1:0] mode;
        logic [2:0] bar;
        logic       fs;
        logic       act;
        logic       vs;
        logic       hs;
    } sb_t;

    localparam sb_t SB_RST = '{mode: 2'b00, bar: 3'd0, fs: 1'b0, act: 1'b0,
                               vs: ~VS_ON, hs: ~HS_ON};

    logic [HW-1:0]   r_hCount;
    logic [VW-1:0]   r_vCount;
    logic [1:0]      r_mode;
    logic [CAW-1:0]  r_colAddr;
    logic [RAW-1:0]  r_rowAddr;
    logic            r_rdn;
    sb_t             r_sbPipe [RD_LAT+1];
    logic [3*CW-1:0] r_rgb;
    logic            r_hs;
    logic            r_vs;
    logic            r_de;
    logic            r_fs;

    logic            w_hLast;
    logic            w_vLast;
    int              w_hInt;
    int              w_vInt;
    logic            w_act;
    logic [CAW-1:0]  w_col;
    logic [RAW-1:0]  w_row;
    sb_t             w_sb0;
    sb_t             w_sbOut;
    logic [3*CW-1:0] w_rgb;

    assign w_hLast = (r_hCount == HW'(H_TOTAL - 1));
    assign w_vLast = (r_vCount == VW'(V_TOTAL - 1));

    // Mode only changes on the last clock of a frame so a frame is never split between modes.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_hCount <= '0;
            r_vCount <= '0;
            r_mode   <= 2'b00;
        end else if (w_hLast) begin
            r_hCount <= '0;
            if (w_vLast) begin
                r_vCount <= '0;
                r_mode   <= mode_in;
            end else begin
                r_vCount <= r_vCount + 1'b1;
            end
        end else begin
            r_hCount <= r_hCount + 1'b1;
        end
    end

    always_comb begin
        w_hInt     = int'(r_hCount);
        w_vInt     = int'(r_vCount);
        w_act      = (w_hInt >= H_START) && (w_hInt < H_END) &&
                     (w_vInt >= V_START) && (w_vInt < V_END);
        w_col      = w_act ? CAW'(w_hInt - H_START) : '0;
        w_row      = w_act ? RAW'(w_vInt - V_START) : '0;
        w_sb0      = SB_RST;
        w_sb0.hs   = (w_hInt < H_SYNC) ? HS_ON : ~HS_ON;
        w_sb0.vs   = (w_vInt < V_SYNC) ? VS_ON : ~VS_ON;
        w_sb0.act  = w_act;
        w_sb0.mode = r_mode;
        w_sb0.fs   = w_act && (w_hInt == H_START) && (w_vInt == V_START);
        w_sb0.bar  = w_act ? 3'((w_hInt - H_START) / BAR_W) : 3'd0;
    end

    // Sideband rides alongside the RAM read so it lands on the same edge that samples d_in.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_colAddr <= '0;
            r_rowAddr <= '0;
            r_rdn     <= 1'b1;
            for (int i = 0; i <= RD_LAT; i++) begin
                r_sbPipe[i] <= SB_RST;
            end
        end else begin
            r_colAddr   <= w_col;
            r_rowAddr   <= w_row;
            r_rdn       <= ~(w_act && (r_mode == 2'b00));
            r_sbPipe[0] <= w_sb0;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_sbPipe[i] <= r_sbPipe[i-1];
            end
        end
    end

    assign w_sbOut = r_sbPipe[RD_LAT];

    // Bar order white..black falls out of inverting bar-index bits: r=~b1, g=~b2, b=~b0.
    always_comb begin
        w_rgb = '0;
        if (w_sbOut.act) begin
            case (w_sbOut.mode)
                2'b00:   w_rgb = d_in;
                2'b01:   w_rgb = {{CW{~w_sbOut.bar[1]}}, {CW{~w_sbOut.bar[2]}},
                                  {CW{~w_sbOut.bar[0]}}};
                2'b10:   w_rgb = fill_color;
                default: w_rgb = '0;
            endcase
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
            r_hs  <= ~HS_ON;
            r_vs  <= ~VS_ON;
            r_de  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_rgb <= w_rgb;
            r_hs  <= w_sbOut.hs;
            r_vs  <= w_sbOut.vs;
            r_de  <= w_sbOut.act;
            r_fs  <= w_sbOut.fs;
        end
    end

    assign row_addr    = r_rowAddr;
    assign col_addr    = r_colAddr;
    assign rdn         = r_rdn;
    assign r           = r_rgb[3*CW-1:2*CW];
    assign g           = r_rgb[2*CW-1:CW];
    assign b           = r_rgb[CW-1:0];
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-width-line/short-frame instance (RD_LAT=3) and a tiny
// positive-sync raster (RD_LAT=1), both compared each cycle against an arithmetic raster model.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

    typedef struct packed {
        int hSync; int hBp; int hAct; int hFp;
        int vSync; int vBp; int vAct; int vFp;
        int hPol;  int vPol; int cw;  int lat;
    } cfg_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
    } vid_t;

    typedef struct packed {
        logic [9:0] col;
        logic [1:0] row;
        logic       rdn;
    } adr_t;

    localparam cfg_t CFG_A = '{hSync: 96, hBp: 48, hAct: 640, hFp: 16,
                               vSync: 2, vBp: 1, vAct: 4, vFp: 1,
                               hPol: 0, vPol: 0, cw: 4, lat: 3};
    localparam cfg_t CFG_B = '{hSync: 2, hBp: 2, hAct: 8, hFp: 2,
                               vSync: 2, vBp: 2, vAct: 4, vFp: 2,
                               hPol: 1, vPol: 1, cw: 2, lat: 1};
    localparam int FT_A = 800 * 8;
    localparam int FT_B = 14 * 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  modeIn = 2'b00;
    logic [11:0] fillA = 12'h5A3;
    logic [5:0]  fillB = 6'h23;
    logic [11:0] dA;
    logic [5:0]  dB;

    logic [1:0]  rowA;
    logic [9:0]  colA;
    logic        rdnA, hsA, vsA, deA, fsA;
    logic [3:0]  rA, gA, bA;
    logic [1:0]  rowB;
    logic [2:0]  colB;
    logic        rdnB, hsB, vsB, deB, fsB;
    logic [1:0]  rB, gB, bB;

    int vectors = 0;
    int miscompares = 0;
    int eCnt = 0;
    int edgeNow = 0;
    bit secondRun = 1'b0;
    int hsCntA = 0, vsCntA = 0, deCntA = 0, fsCntA = 0;
    int hsCntB = 0, vsCntB = 0, deCntB = 0, fsCntB = 0;
    logic [1:0] fmA [512];
    logic [1:0] fmB [512];
    logic [11:0] ramPipeA [3];
    logic [5:0]  ramPipeB [1];

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .CW(4), .RD_LAT(3)
    ) dutA (
        .vga_clk(clk), .rst(rst), .mode_in(modeIn), .fill_color(fillA), .d_in(dA),
        .row_addr(rowA), .col_addr(colA), .rdn(rdnA), .r(rA), .g(gA), .b(bA),
        .hs(hsA), .vs(vsA), .de(deA), .frame_start(fsA)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1), .VS_POL(1), .CW(2), .RD_LAT(1)
    ) dutB (
        .vga_clk(clk), .rst(rst), .mode_in(modeIn), .fill_color(fillB), .d_in(dB),
        .row_addr(rowB), .col_addr(colB), .rdn(rdnB), .r(rB), .g(gB), .b(bB),
        .hs(hsB), .vs(vsB), .de(deB), .frame_start(fsB)
    );

    // Pixel content stored in the frame buffer, as a function of position.
    function automatic int ramVal(cfg_t c, int row, int col);
        if (c.cw == 4) return ((row % 16) << 8) | (col % 256);
        return (row * 8 + col) % 64;
    endfunction

    function automatic int barVal(cfg_t c, int idx);
        logic [2:0] bars [8];
        logic [2:0] sel;
        int ones;
        bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        sel  = bars[idx % 8];
        ones = (1 << c.cw) - 1;
        return ((sel[2] ? ones : 0) << (2 * c.cw)) | ((sel[1] ? ones : 0) << c.cw) |
               (sel[0] ? ones : 0);
    endfunction

    // Raster position p (counter index since reset) decides everything the output shows.
    function automatic vid_t modelVideo(cfg_t c, int p, logic [1:0] m, logic [11:0] fill);
        vid_t o;
        int ht, vt, h, v, col, row;
        ht    = c.hSync + c.hBp + c.hAct + c.hFp;
        vt    = c.vSync + c.vBp + c.vAct + c.vFp;
        o.rgb = '0;
        o.de  = 1'b0;
        o.fs  = 1'b0;
        o.hs  = ~c.hPol[0];
        o.vs  = ~c.vPol[0];
        if (p < 0) return o;
        h    = p % ht;
        v    = (p / ht) % vt;
        col  = h - (c.hSync + c.hBp);
        row  = v - (c.vSync + c.vBp);
        o.hs = (h < c.hSync) ? c.hPol[0] : ~c.hPol[0];
        o.vs = (v < c.vSync) ? c.vPol[0] : ~c.vPol[0];
        o.de = (col >= 0) && (col < c.hAct) && (row >= 0) && (row < c.vAct);
        o.fs = o.de && (row == 0) && (col == 0);
        if (o.de) begin
            case (m)
                2'b00:   o.rgb = 12'(ramVal(c, row, col));
                2'b01:   o.rgb = 12'(barVal(c, col / (c.hAct / 8)));
                2'b10:   o.rgb = fill;
                default: o.rgb = '0;
            endcase
        end
        return o;
    endfunction

    function automatic adr_t modelAddr(cfg_t c, int p, logic [1:0] m);
        adr_t o;
        int ht, vt, col, row;
        ht    = c.hSync + c.hBp + c.hAct + c.hFp;
        vt    = c.vSync + c.vBp + c.vAct + c.vFp;
        o.col = '0;
        o.row = '0;
        o.rdn = 1'b1;
        if (p < 0) return o;
        col = (p % ht) - (c.hSync + c.hBp);
        row = ((p / ht) % vt) - (c.vSync + c.vBp);
        if ((col >= 0) && (col < c.hAct) && (row >= 0) && (row < c.vAct)) begin
            o.col = 10'(col);
            o.row = 2'(row);
            o.rdn = (m != 2'b00);
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: got %h, want %h", name, eCnt, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m);
        modeIn = m;
        $display("[TB] mode_in set to %b at edge %0d", m, edgeNow);
    endtask

    task automatic goToEdge(input int target);
        while (edgeNow < target) begin
            @(posedge clk);
            edgeNow++;
        end
        @(negedge clk);
    endtask

    // Behavioural frame-buffer RAM: data appears lat clocks after the address.
    always @(posedge clk) begin
        ramPipeA[0] <= rdnA ? 12'hBAD : 12'(ramVal(CFG_A, int'(rowA), int'(colA)));
        ramPipeA[1] <= ramPipeA[0];
        ramPipeA[2] <= ramPipeA[1];
        ramPipeB[0] <= rdnB ? 6'h2A : 6'(ramVal(CFG_B, int'(rowB), int'(colB)));
    end
    assign dA = ramPipeA[2];
    assign dB = ramPipeB[0];

    // Edge count since reset release, and the mode each frame is expected to use.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eCnt   <= 0;
            fmA[0] <= 2'b00;
            fmB[0] <= 2'b00;
        end else begin
            eCnt <= eCnt + 1;
            if ((eCnt + 1) % FT_A == 0) fmA[((eCnt + 1) / FT_A) % 512] <= modeIn;
            if ((eCnt + 1) % FT_B == 0) fmB[((eCnt + 1) / FT_B) % 512] <= modeIn;
        end
    end

    always @(negedge clk) begin : compare
        int pA, pB;
        logic [1:0] mA, mB, maA, maB;
        vid_t gotA, gotB;
        adr_t adrA, adrB;
        pA   = eCnt - (CFG_A.lat + 2);
        pB   = eCnt - (CFG_B.lat + 2);
        mA   = (pA < 0) ? 2'b00 : fmA[(pA / FT_A) % 512];
        mB   = (pB < 0) ? 2'b00 : fmB[(pB / FT_B) % 512];
        maA  = (eCnt < 1) ? 2'b00 : fmA[((eCnt - 1) / FT_A) % 512];
        maB  = (eCnt < 1) ? 2'b00 : fmB[((eCnt - 1) / FT_B) % 512];
        gotA = {rA, gA, bA, hsA, vsA, deA, fsA};
        gotB = {6'b0, rB, gB, bB, hsB, vsB, deB, fsB};
        adrA = {colA, rowA, rdnA};
        adrB = {7'b0, colB, rowB, rdnB};
        checkOutput("videoA", 32'(gotA), 32'(modelVideo(CFG_A, pA, mA, fillA)));
        checkOutput("videoB", 32'(gotB), 32'(modelVideo(CFG_B, pB, mB, {6'b0, fillB})));
        checkOutput("addrA", 32'(adrA), 32'(modelAddr(CFG_A, eCnt - 1, maA)));
        checkOutput("addrB", 32'(adrB), 32'(modelAddr(CFG_B, eCnt - 1, maB)));
        if (!rst && !secondRun) begin
            if (eCnt >= FT_A + 5 && eCnt < 2 * FT_A + 5) begin
                if (!hsA) hsCntA++;
                if (!vsA) vsCntA++;
                if (deA)  deCntA++;
                if (fsA)  fsCntA++;
            end
            if (eCnt >= 3 * FT_B + 3 && eCnt < 4 * FT_B + 3) begin
                if (hsB) hsCntB++;
                if (vsB) vsCntB++;
                if (deB) deCntB++;
                if (fsB) fsCntB++;
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rstHsA", 32'(hsA), 32'd1);
        checkOutput("rstVsB", 32'(vsB), 32'd0);
        checkOutput("rstRdnA", 32'(rdnA), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        edgeNow = 0;

        goToEdge(2549);
        checkOutput("f0FirstFs", 32'(fsA), 32'd1);
        checkOutput("f0FirstDe", 32'(deA), 32'd1);
        checkOutput("f0FirstRgb", 32'({rA, gA, bA}), 32'h000);
        goToEdge(2849);
        checkOutput("ramR0C300", 32'({rA, gA, bA}), 32'h02C);
        goToEdge(3000);
        applyStimulus(2'b10);
        goToEdge(3354);
        checkOutput("ramR1C5", 32'({rA, gA, bA}), 32'h105);
        goToEdge(8949);
        checkOutput("fillFirst", 32'({rA, gA, bA}), 32'h5A3);
        checkOutput("fillFs", 32'(fsA), 32'd1);
        goToEdge(9000);
        applyStimulus(2'b01);
        goToEdge(15349);
        checkOutput("barCol0", 32'({rA, gA, bA}), 32'hFFF);
        checkOutput("barRdn", 32'(rdnA), 32'd1);
        goToEdge(15429);
        checkOutput("barCol80", 32'({rA, gA, bA}), 32'hFF0);
        goToEdge(15509);
        checkOutput("barCol160", 32'({rA, gA, bA}), 32'h0FF);
        goToEdge(15909);
        checkOutput("barCol560", 32'({rA, gA, bA}), 32'h000);
        goToEdge(16000);
        applyStimulus(2'b11);
        goToEdge(21749);
        checkOutput("blankRgb", 32'({rA, gA, bA}), 32'h000);
        checkOutput("blankFs", 32'(fsA), 32'd1);
        goToEdge(22000);
        applyStimulus(2'b00);
        goToEdge(28149);
        checkOutput("ramAgainFs", 32'(fsA), 32'd1);

        checkOutput("hsPerFrameA", 32'(hsCntA), 32'd768);
        checkOutput("vsPerFrameA", 32'(vsCntA), 32'd1600);
        checkOutput("dePerFrameA", 32'(deCntA), 32'd2560);
        checkOutput("fsPerFrameA", 32'(fsCntA), 32'd1);
        checkOutput("hsPerFrameB", 32'(hsCntB), 32'd20);
        checkOutput("vsPerFrameB", 32'(vsCntB), 32'd28);
        checkOutput("dePerFrameB", 32'(deCntB), 32'd32);
        checkOutput("fsPerFrameB", 32'(fsCntB), 32'd1);

        goToEdge(28500);
        applyStimulus(2'b10);
        goToEdge(28601);
        checkOutput("preRstDe", 32'(deA), 32'd1);
        checkOutput("preRstRgb", 32'({rA, gA, bA}), 32'h0C4);
        #2 rst = 1'b1;
        secondRun = 1'b1;
        #1;
        checkOutput("midRstRgbA", 32'({rA, gA, bA}), 32'h000);
        checkOutput("midRstDeA", 32'(deA), 32'd0);
        checkOutput("midRstHsA", 32'(hsA), 32'd1);
        checkOutput("midRstColA", 32'(colA), 32'd0);
        checkOutput("midRstHsB", 32'(hsB), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        edgeNow = 0;

        goToEdge(2);
        checkOutput("hsB@2", 32'(hsB), 32'd0);
        goToEdge(3);
        checkOutput("hsB@3", 32'(hsB), 32'd1);
        goToEdge(4);
        checkOutput("hsA@4", 32'(hsA), 32'd1);
        goToEdge(5);
        checkOutput("hsA@5", 32'(hsA), 32'd0);
        goToEdge(2849);
        checkOutput("modeRst00", 32'({rA, gA, bA}), 32'h02C);
        goToEdge(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Parametrised VGA timing and pixel-output controller. It generates programmable horizontal and vertical timing, drives pixel-RAM read addresses, and aligns returned pixel data with the sync signals across a configurable source read latency. It adds frame-synchronous mode selection (RAM pixels, colour bars, solid fill, blank), selectable sync polarity, a data-enable output and a frame-start marker. It sits between the frame-buffer RAM and the board VGA connector, clocked at the pixel rate.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hs active level (0 = active-low pulse)
- VS_POL, 0, vs active level
- CW, 4, bits per colour channel
- RD_LAT, 1, pixel source read latency in clocks, legal range 1..4

Ports:
- vga_clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- mode_in  in  2  00 RAM pixels, 01 colour bars, 10 solid fill, 11 blank
- fill_color  in  3*CW  {r,g,b} colour used in mode 10
- d_in  in  3*CW  {r,g,b} pixel returned by the source
- row_addr  out  clog2(V_ACTIVE)  pixel row address
- col_addr  out  clog2(H_ACTIVE)  pixel column address
- rdn  out  1  read strobe, active low
- r, g, b  out  CW each  colour outputs
- hs, vs  out  1  sync outputs
- de  out  1  output pixel is visible
- frame_start  out  1  one-clock marker on the first visible pixel of a frame

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP. V_TOTAL is defined the same way.
- h_count runs 0..H_TOTAL-1 and wraps. v_count increments when h_count = H_TOTAL-1 and wraps at V_TOTAL-1. Counter widths are clog2 of the totals.
- Segment order per axis: sync, back porch, active, front porch.
  - Sync is asserted for h_count < H_SYNC.
  - Active columns are H_SYNC+H_BP ≤ h_count < H_SYNC+H_BP+H_ACTIVE. Vertical segments follow the same pattern.
- Address stage:
  - When both axes are active: col_addr = h_count-(H_SYNC+H_BP), row_addr = v_count-(V_SYNC+V_BP), and rdn = 0 in mode 00.
  - Outside the active region: addresses are 0 and rdn = 1.
  - In modes 01, 10 and 11, rdn stays 1 at all times.
- Output colour, gated by the delayed active flag; colour is 0 when not active:
  - Mode 00: d_in.
  - Mode 01: eight bars, each H_ACTIVE/8 columns wide, indexed by col_addr/(H_ACTIVE/8). Order is white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0.
  - Mode 10: fill_color.
  - Mode 11: 0.
- Mode latching:
  - mode_in is sampled into an internal mode register only at the frame boundary (h_count = H_TOTAL-1 and v_count = V_TOTAL-1).
  - A mid-frame change never affects the current frame.
  - The mode register resets to 00.
- frame_start is high on exactly the output cycle carrying row 0, column 0, in every mode.

## Timing
- Reset values:
  - Counters 0, mode 00.
  - row_addr = col_addr = 0, rdn = 1.
  - r = g = b = 0, de = 0, frame_start = 0.
  - hs = ~HS_POL, vs = ~VS_POL.
- Reset acts immediately and asynchronously, including mid-line. Timing restarts from count 0 on the first clock after release.
- Pipeline:
  - row_addr, col_addr and rdn are registered one clock after the counter state.
  - The source presents d_in RD_LAT clocks after the address.
  - r/g/b, hs, vs, de and frame_start are registered on the edge that samples d_in.
  - Total latency from counter state to output is RD_LAT+2 clocks.
  - hs, vs, active flag, bar index and frame_start pass through matching delay stages, so they stay cycle-aligned with colour in every mode.
- Per line: hs is active for exactly H_SYNC clocks and de is high for exactly H_ACTIVE consecutive clocks.
- Per frame: vs is active for exactly V_SYNC·H_TOTAL clocks and de is high on V_ACTIVE lines.
- vs transitions are aligned with hs line starts: both are delayed by the same pipeline.

## Test plan
- Assert rst mid-line at arbitrary counts → all outputs take reset values within the same cycle. After release, the first hs pulse starts RD_LAT+2 clocks later.
- Default parameters, mode 00, 2 frames:
  - hs low 96 of every 800 clocks.
  - vs low 1600 of every 420000 clocks.
  - de high 640 clocks per line on 480 lines.
  - Exactly one frame_start per frame.
- RD_LAT=3 with a behavioural RAM returning d_in = {row[3:0], col[7:0]} → each output pixel equals the value for its own (row, col). The pixel with de high and frame_start high is 0x000.
- Mode 01 → colour 0xFFF at col 0, 0xFF0 at col 80, 0x0FF at col 160, 0x000 at col 560. rdn stays 1 throughout.
- Change mode_in 00→10 (fill_color 0x5A3) mid-frame → current frame stays RAM data. The next frame's first pixel is 0x5A3.
- H_ACTIVE=8, all porches 2, V_ACTIVE=4, HS_POL=VS_POL=1, CW=2 → hs high 2 of 14 clocks, 8 de clocks per line, counters wrap correctly.
